// File: rtl/lsu_access_seq.sv
// Memory-stage load/store sequencer.
// Turns a decoded access code into one or two word-wide data-memory
// transactions over a req/ack handshake, merges and extends load data,
// and stalls the pipeline while an access is in flight.
module lsu_access_seq (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_mem_wren,
    input  logic [2:0]  i_slt_sl,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_st_data,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_ld_data,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_bmask,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Latched access attributes
    logic        dir_q;      // 1 = store
    logic        split_q;
    logic        sext_q;
    logic [2:0]  size_q;     // bytes: 1, 2 or 4
    logic [1:0]  off_q;
    logic [31:0] addr1_q;
    logic [31:0] wdata1_q;
    logic [3:0]  bmask1_q;
    logic [31:0] rdata0_q;

    // Decode of the incoming access
    logic [2:0]  size_in;
    logic        sext_in;
    logic [1:0]  off_in;
    logic        split_in;
    logic [7:0]  mask_in;
    logic [63:0] wwin_in;
    logic [31:0] word0_in;

    // Size/sign decode; illegal size codes for the direction fall back to a word
    always_comb begin
        size_in = 3'd4;
        sext_in = 1'b0;
        if (i_mem_wren) begin
            case (i_slt_sl)
                3'b000:  size_in = 3'd1;
                3'b001:  size_in = 3'd2;
                default: size_in = 3'd4;
            endcase
        end else begin
            case (i_slt_sl)
                3'b011:  begin size_in = 3'd1; sext_in = 1'b1; end
                3'b100:  begin size_in = 3'd2; sext_in = 1'b1; end
                3'b110:  size_in = 3'd1;
                3'b111:  size_in = 3'd2;
                default: size_in = 3'd4;
            endcase
        end
    end

    // Lane placement: a 64-bit window spanning word0 (low) and word1 (high)
    always_comb begin
        off_in   = i_addr[1:0];
        split_in = (({1'b0, off_in} + size_in) > 3'd4);
        mask_in  = ((8'd1 << size_in) - 8'd1) << off_in;
        wwin_in  = i_mem_wren ? ({32'd0, i_st_data} << {off_in, 3'b000}) : 64'd0;
        word0_in = {i_addr[31:2], 2'b00};
    end

    logic accept;
    logic ack0;
    logic ack1;
    logic last_ack;

    // Handshake events
    always_comb begin
        accept   = (state == IDLE) && i_req;
        ack0     = (state == ACC0) && i_dmem_ack;
        ack1     = (state == ACC1) && i_dmem_ack;
        last_ack = (ack0 && !split_q) || ack1;
    end

    // Next-state logic and status outputs
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_req) state_nxt = ACC0;
            ACC0: if (i_dmem_ack) state_nxt = split_q ? ACC1 : DONE;
            ACC1: if (i_dmem_ack) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_dmem_req = (state == ACC0) || (state == ACC1);
        o_dmem_we  = o_dmem_req && dir_q;
        o_done     = (state == DONE);
        o_stall    = accept || o_dmem_req;
    end

    // Load merge: select the field from {rdata1, rdata0} and extend it
    logic [63:0] rwin;
    logic [63:0] rshift;
    logic [31:0] ld_val;

    always_comb begin
        rwin   = ack1 ? {i_dmem_rdata, rdata0_q} : {32'd0, i_dmem_rdata};
        rshift = rwin >> {off_q, 3'b000};
        case (size_q)
            3'd1:    ld_val = sext_q ? {{24{rshift[7]}}, rshift[7:0]}
                                     : {24'd0, rshift[7:0]};
            3'd2:    ld_val = sext_q ? {{16{rshift[15]}}, rshift[15:0]}
                                     : {16'd0, rshift[15:0]};
            default: ld_val = rshift[31:0];
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Access latch; word0 fields go straight to the memory-side registers,
    // word1 fields are parked until word0 is acknowledged
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dir_q        <= 1'b0;
            split_q      <= 1'b0;
            sext_q       <= 1'b0;
            size_q       <= 3'd4;
            off_q        <= 2'd0;
            addr1_q      <= 32'd0;
            wdata1_q     <= 32'd0;
            bmask1_q     <= 4'd0;
            o_dmem_addr  <= 32'd0;
            o_dmem_wdata <= 32'd0;
            o_dmem_bmask <= 4'd0;
        end else if (accept) begin
            dir_q        <= i_mem_wren;
            split_q      <= split_in;
            sext_q       <= sext_in;
            size_q       <= size_in;
            off_q        <= off_in;
            addr1_q      <= word0_in + 32'd4;  // wraps at the top of memory
            wdata1_q     <= wwin_in[63:32];
            bmask1_q     <= mask_in[7:4];
            o_dmem_addr  <= word0_in;
            o_dmem_wdata <= wwin_in[31:0];
            o_dmem_bmask <= mask_in[3:0];
        end else if (ack0 && split_q) begin
            o_dmem_addr  <= addr1_q;
            o_dmem_wdata <= wdata1_q;
            o_dmem_bmask <= bmask1_q;
        end
    end

    // Read data capture and load result register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata0_q  <= 32'd0;
            o_ld_data <= 32'd0;
        end else begin
            if (ack0) rdata0_q <= i_dmem_rdata;
            if (last_ack && !dir_q) o_ld_data <= ld_val;
        end
    end

endmodule

// File: tb/tb_lsu_access_seq.sv
// Bench for lsu_access_seq: table of accesses driven through a simple
// memory responder; expected requests and load results are queued on issue
// and popped as the design produces them.
module tb_lsu_access_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, wren;
    logic [2:0]  code;
    logic [31:0] addr, st_data;
    logic        stall, done;
    logic [31:0] ld_data;
    logic        dreq, dwe;
    logic [31:0] daddr, dwdata;
    logic [3:0]  dbmask;
    logic        dack;
    logic [31:0] drdata;

    always #5 clk = ~clk;

    lsu_access_seq dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_mem_wren(wren),
        .i_slt_sl(code), .i_addr(addr), .i_st_data(st_data),
        .o_stall(stall), .o_done(done), .o_ld_data(ld_data),
        .o_dmem_req(dreq), .o_dmem_we(dwe), .o_dmem_addr(daddr),
        .o_dmem_wdata(dwdata), .o_dmem_bmask(dbmask),
        .i_dmem_ack(dack), .i_dmem_rdata(drdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  code;
        logic [31:0] addr, st, rd0, rd1;
        int          w0, w1;
        logic        split;
        logic [31:0] a0;  logic [3:0] m0; logic [31:0] wd0;
        logic [31:0] a1;  logic [3:0] m1; logic [31:0] wd1;
        logic [31:0] ld;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [3:0]  m;
        logic [31:0] wd;
    } req_t;

    req_t        req_q[$];
    logic [31:0] ld_q[$];
    logic [31:0] last_ld;
    int checks = 0;
    int errors = 0;
    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic we, input logic [2:0] c,
            input logic [31:0] a, input logic [31:0] st, input logic [31:0] rd0,
            input logic [31:0] rd1, input int w0, input int w1, input logic sp,
            input logic [31:0] a0, input logic [3:0] m0, input logic [31:0] wd0,
            input logic [31:0] a1, input logic [3:0] m1, input logic [31:0] wd1,
            input logic [31:0] ld);
        vec_t v;
        v.we = we; v.code = c; v.addr = a; v.st = st; v.rd0 = rd0; v.rd1 = rd1;
        v.w0 = w0; v.w1 = w1; v.split = sp;
        v.a0 = a0; v.m0 = m0; v.wd0 = wd0; v.a1 = a1; v.m1 = m1; v.wd1 = wd1;
        v.ld = ld;
        return v;
    endfunction

    // Issue one access and act as memory until o_done or the cycle budget runs out
    task automatic run(input vec_t v);
        req_t r;
        int   cyc, words, w, exp_cyc;
        bit   fin;
        @(negedge clk);
        req = 1'b1; wren = v.we; code = v.code; addr = v.addr; st_data = v.st;
        r.we = v.we; r.a = v.a0; r.m = v.m0; r.wd = v.wd0;
        req_q.push_back(r);
        if (v.split) begin
            r.a = v.a1; r.m = v.m1; r.wd = v.wd1;
            req_q.push_back(r);
        end
        if (!v.we) last_ld = v.ld;
        ld_q.push_back(last_ld);
        exp_cyc = 2 + (v.split ? 1 : 0) + v.w0 + v.w1;
        #1 chk("stall_at_accept", {31'd0, stall}, 32'd1);
        @(negedge clk);
        req = 1'b0;
        cyc = 1; words = 0; w = v.w0; fin = 0;
        while (!fin && cyc < 40) begin
            dack = 1'b0;
            if (done) begin
                chk("ld_data", ld_data, ld_q.pop_front());
                chk("stall_in_done", {31'd0, stall}, 32'd0);
                chk("latency", cyc, exp_cyc);
                fin = 1;
            end else if (dreq && req_q.size() > 0) begin
                r = req_q[0];
                chk("stall_busy", {31'd0, stall}, 32'd1);
                chk("dmem_we", {31'd0, dwe}, {31'd0, r.we});
                chk("dmem_addr", daddr, r.a);
                chk("dmem_bmask", {28'd0, dbmask}, {28'd0, r.m});
                chk("dmem_wdata", dwdata, r.wd);
                if (w > 0) begin
                    w--;
                end else begin
                    dack = 1'b1;
                    drdata = (words == 0) ? v.rd0 : v.rd1;
                    void'(req_q.pop_front());
                    words++;
                    w = v.w1;
                end
            end else begin
                chk("unexpected_idle", {31'd0, dreq}, 32'd1);
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        dack = 1'b0;
        if (!fin) begin
            chk("timeout_no_done", 32'd0, 32'd1);
            req_q.delete();
            ld_q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 0; wren = 0; code = 0; addr = 0; st_data = 0;
        dack = 0; drdata = 0; last_ld = 32'd0;

        //           we  code    addr          st            rd0           rd1           w0 w1 sp a0            m0       wd0           a1            m1       wd1           ld
        vecs[0]  = mkv(0, 3'b101, 32'h0000_0100, 32'h0,        32'h8000_00F0, 32'h0,        0, 0, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h8000_00F0);
        vecs[1]  = mkv(0, 3'b011, 32'h0000_0203, 32'h0,        32'h9A00_0000, 32'h0,        0, 0, 0, 32'h0000_0200, 4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFF_FF9A);
        vecs[2]  = mkv(0, 3'b110, 32'h0000_0203, 32'h0,        32'h9A00_0000, 32'h0,        0, 0, 0, 32'h0000_0200, 4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_009A);
        vecs[3]  = mkv(1, 3'b010, 32'h0000_01FE, 32'h1122_3344, 32'h0,        32'h0,        0, 0, 1, 32'h0000_01FC, 4'b1100, 32'h3344_0000, 32'h0000_0200, 4'b0011, 32'h0000_1122, 32'h0);
        vecs[4]  = mkv(0, 3'b100, 32'hFFFF_FFFF, 32'h0,        32'h7F00_0000, 32'h0000_0080, 0, 0, 1, 32'hFFFF_FFFC, 4'b1000, 32'h0,        32'h0000_0000, 4'b0001, 32'h0,        32'hFFFF_807F);
        vecs[5]  = mkv(1, 3'b001, 32'h0000_0042, 32'h0000_BEEF, 32'h0,        32'h0,        3, 0, 0, 32'h0000_0040, 4'b1100, 32'hBEEF_0000, 32'h0,        4'b0000, 32'h0,        32'h0);
        vecs[6]  = mkv(1, 3'b000, 32'h0000_0007, 32'hAABB_CCDD, 32'h0,        32'h0,        1, 0, 0, 32'h0000_0004, 4'b1000, 32'hDD00_0000, 32'h0,        4'b0000, 32'h0,        32'h0);
        vecs[7]  = mkv(1, 3'b111, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,        32'h0,        0, 0, 0, 32'h0000_0010, 4'b1111, 32'hCAFE_F00D, 32'h0,        4'b0000, 32'h0,        32'h0);
        vecs[8]  = mkv(0, 3'b000, 32'h0000_0020, 32'h0,        32'h1234_5678, 32'h0,        0, 0, 0, 32'h0000_0020, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h1234_5678);
        vecs[9]  = mkv(0, 3'b111, 32'h0000_0003, 32'h0,        32'hAB00_0000, 32'h0000_00CD, 0, 0, 1, 32'h0000_0000, 4'b1000, 32'h0,        32'h0000_0004, 4'b0001, 32'h0,        32'h0000_CDAB);
        vecs[10] = mkv(0, 3'b101, 32'h0000_0005, 32'h0,        32'h3322_1100, 32'h0000_0044, 1, 2, 1, 32'h0000_0004, 4'b1110, 32'h0,        32'h0000_0008, 4'b0001, 32'h0,        32'h4433_2211);
        vecs[11] = mkv(0, 3'b100, 32'h0000_0002, 32'h0,        32'h7FFE_0000, 32'h0,        0, 0, 0, 32'h0000_0000, 4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_7FFE);

        // Reset values
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, dreq}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_addr", daddr, 32'd0);
        chk("rst_ld", ld_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Stray ack while idle must not start or finish anything
        @(negedge clk);
        dack = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ack_req", {31'd0, dreq}, 32'd0);
        chk("idle_ack_done", {31'd0, done}, 32'd0);
        dack = 1'b0;

        for (int i = 0; i < 12; i++) run(vecs[i]);

        // Reset in the middle of the second word of a split lw
        @(negedge clk);
        req = 1'b1; wren = 1'b0; code = 3'b101; addr = 32'h0000_0101;
        @(negedge clk);
        req = 1'b0;
        dack = 1'b1; drdata = 32'h5555_5555;
        @(negedge clk);
        dack = 1'b0;
        chk("acc1_req", {31'd0, dreq}, 32'd1);
        chk("acc1_addr", daddr, 32'h0000_0104);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'd0, dreq}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_we", {31'd0, dwe}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_bmask", {28'd0, dbmask}, 32'd0);
        chk("midrst_ld", ld_data, 32'd0);
        dack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_req", {31'd0, dreq}, 32'd0);
        chk("postrst_done", {31'd0, done}, 32'd0);
        dack = 1'b0;
        last_ld = 32'd0;
        run(mkv(1, 3'b010, 32'h0000_0300, 32'h0BAD_CAFE, 32'h0, 32'h0, 0, 0, 0,
                32'h0000_0300, 4'b1111, 32'h0BAD_CAFE, 32'h0, 4'b0000, 32'h0, 32'h0));

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
